// File: rtl/bsg_manycore_sdr_reset_sequencer_if.sv
// bsg_manycore_sdr_reset_sequencer_if: host trigger, status and row reset outputs of the sequencer
interface bsg_manycore_sdr_reset_sequencer_if;
    logic       start_i;
    logic       busy_o;
    logic       done_o;
    logic [2:0] state_o;
    logic       async_uplink_reset_o;
    logic       async_downlink_reset_o;
    logic       async_downstream_reset_o;
    logic       async_token_reset_o;
    logic       core_reset_o;
    modport master (
        output start_i,
        input  busy_o, done_o, state_o, async_uplink_reset_o, async_downlink_reset_o,
               async_downstream_reset_o, async_token_reset_o, core_reset_o
    );
    modport slave (
        input  start_i,
        output busy_o, done_o, state_o, async_uplink_reset_o, async_downlink_reset_o,
               async_downstream_reset_o, async_token_reset_o, core_reset_o
    );
endinterface

// File: rtl/bsg_manycore_sdr_reset_sequencer.sv
// bsg_manycore_sdr_reset_sequencer: walks one SDR link row through its ordered reset bring-up
module bsg_manycore_sdr_reset_sequencer #(
    parameter int phase_cycles_p       = 16,
    parameter int token_pulse_cycles_p = 4
) (
    input logic                               core_clk_i,
    input logic                               core_reset_i,
    bsg_manycore_sdr_reset_sequencer_if.slave io
);
    localparam int max_cycles_lp   = phase_cycles_p > token_pulse_cycles_p ? phase_cycles_p : token_pulse_cycles_p;
    localparam int lg_cnt_width_lp = $clog2(max_cycles_lp + 1);
    localparam logic [lg_cnt_width_lp-1:0] phase_last_lp = lg_cnt_width_lp'(phase_cycles_p - 1);
    localparam logic [lg_cnt_width_lp-1:0] token_last_lp = lg_cnt_width_lp'(token_pulse_cycles_p - 1);
    typedef enum logic [2:0] {IDLE, ASSERT, TOKEN, TGAP, UP_REL, DN_REL, DS_REL, DONE} state_e;
    state_e                     state_r, state_n;
    logic [lg_cnt_width_lp-1:0] cnt_r, cnt_n;
    logic                       last;
    logic                       up_n, dn_n, ds_n, tok_n, core_n, busy_n, done_n;
    assign last       = cnt_r == (state_r == TOKEN ? token_last_lp : phase_last_lp);
    assign io.state_o = state_r;
    // Outputs are registered decodes of the next state so each one is a clean flop into other domains
    always_ff @(posedge core_clk_i or posedge core_reset_i) begin
        if (core_reset_i) begin
            state_r                     <= IDLE;
            cnt_r                       <= '0;
            io.async_uplink_reset_o     <= 1'b1;
            io.async_downlink_reset_o   <= 1'b1;
            io.async_downstream_reset_o <= 1'b1;
            io.async_token_reset_o      <= 1'b0;
            io.core_reset_o             <= 1'b1;
            io.busy_o                   <= 1'b0;
            io.done_o                   <= 1'b0;
        end else begin
            state_r                     <= state_n;
            cnt_r                       <= cnt_n;
            io.async_uplink_reset_o     <= up_n;
            io.async_downlink_reset_o   <= dn_n;
            io.async_downstream_reset_o <= ds_n;
            io.async_token_reset_o      <= tok_n;
            io.core_reset_o             <= core_n;
            io.busy_o                   <= busy_n;
            io.done_o                   <= done_n;
        end
    end
    always_comb begin
        state_n = state_r;
        cnt_n   = '0;
        if (state_r == IDLE || state_r == DONE)
            state_n = io.start_i ? ASSERT : state_r;
        else if (last)
            state_n = state_e'(state_r + 3'd1);
        else
            cnt_n = cnt_r + lg_cnt_width_lp'(1);
    end
    always_comb begin
        up_n   = state_n < UP_REL;
        dn_n   = state_n < DN_REL;
        ds_n   = state_n < DS_REL;
        tok_n  = state_n == TOKEN;
        core_n = state_n != DONE;
        busy_n = state_n != IDLE && state_n != DONE;
        done_n = state_n == DONE;
    end
endmodule

// File: tb/tb_bsg_manycore_sdr_reset_sequencer.sv
// tb_bsg_manycore_sdr_reset_sequencer: timeline reference model plus spec timing tables for P=4,T=2 and P=1,T=1
module tb_bsg_manycore_sdr_reset_sequencer;
    localparam logic [9:0] idle_v = 10'b000_00_111_0_1;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    bsg_manycore_sdr_reset_sequencer_if a ();
    bsg_manycore_sdr_reset_sequencer_if b ();
    bsg_manycore_sdr_reset_sequencer #(.phase_cycles_p(4), .token_pulse_cycles_p(2)) u_a (
        .core_clk_i(clk), .core_reset_i(rst), .io(a));
    bsg_manycore_sdr_reset_sequencer #(.phase_cycles_p(1), .token_pulse_cycles_p(1)) u_b (
        .core_clk_i(clk), .core_reset_i(rst), .io(b));
    int  tests  = 0;
    int  failed = 0;
    bit  chk_en = 0;
    bit  st_a, st_b;
    int  e_a, e_b;
    wire [9:0] got_a = {a.state_o, a.busy_o, a.done_o, a.async_uplink_reset_o, a.async_downlink_reset_o,
                        a.async_downstream_reset_o, a.async_token_reset_o, a.core_reset_o};
    wire [9:0] got_b = {b.state_o, b.busy_o, b.done_o, b.async_uplink_reset_o, b.async_downlink_reset_o,
                        b.async_downstream_reset_o, b.async_token_reset_o, b.core_reset_o};
    wire [5:0] six_a = {a.async_token_reset_o, a.async_uplink_reset_o, a.async_downlink_reset_o,
                        a.async_downstream_reset_o, a.core_reset_o, a.done_o};
    wire [5:0] six_b = {b.async_token_reset_o, b.async_uplink_reset_o, b.async_downlink_reset_o,
                        b.async_downstream_reset_o, b.core_reset_o, b.done_o};
    typedef struct {bit d; int off; logic [5:0] exp;} vec_t;
    vec_t tab[$];
    // Expected outputs from elapsed cycles since the start edge, using the phase boundaries directly
    function automatic logic [9:0] ref_out(input int p, input int t, input bit st, input int e);
        int l = 5 * p + t;
        logic [2:0] s;
        if (!st) return idle_v;
        s = e < p ? 3'd1 : e < p + t ? 3'd2 : e < 2 * p + t ? 3'd3 : e < 3 * p + t ? 3'd4 :
            e < 4 * p + t ? 3'd5 : e < l ? 3'd6 : 3'd7;
        return {s, e < l, e >= l, e < 2 * p + t, e < 3 * p + t, e < 4 * p + t, e >= p && e < p + t, e < l};
    endfunction
    task automatic check(input string name, input logic [9:0] got, input logic [9:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s got=%b exp=%b at %0t", name, got, exp, $time);
        end
    endtask
    always @(posedge clk or posedge rst)
        if (rst) begin
            st_a <= 0;
            e_a  <= 0;
        end else if ((!st_a || e_a >= 22) && a.start_i) begin
            st_a <= 1;
            e_a  <= 0;
        end else if (st_a && e_a < 22) e_a <= e_a + 1;
    always @(posedge clk or posedge rst)
        if (rst) begin
            st_b <= 0;
            e_b  <= 0;
        end else if ((!st_b || e_b >= 6) && b.start_i) begin
            st_b <= 1;
            e_b  <= 0;
        end else if (st_b && e_b < 6) e_b <= e_b + 1;
    always @(negedge clk)
        if (chk_en) begin
            check("model_a", got_a, ref_out(4, 2, st_a, e_a));
            check("model_b", got_b, ref_out(1, 1, st_b, e_b));
            check("tok_safe_a", 10'(a.async_token_reset_o & ~(a.async_uplink_reset_o & a.async_downlink_reset_o & a.async_downstream_reset_o)), 10'd0);
            check("tok_safe_b", 10'(b.async_token_reset_o & ~(b.async_uplink_reset_o & b.async_downlink_reset_o & b.async_downstream_reset_o)), 10'd0);
        end
    // Called at a negedge; start is seen on the next edge k, extra pulses land on edges k+x1 and k+x2
    task automatic run_seq(input bit d, input int x1, input int x2, input int len);
        if (d) b.start_i = 1'b1; else a.start_i = 1'b1;
        for (int o = 0; o < len; o++) begin
            @(negedge clk);
            if (d) b.start_i = 1'b0; else a.start_i = (o + 1 == x1) || (o + 1 == x2);
            foreach (tab[i])
                if (tab[i].d == d && tab[i].off == o)
                    check($sformatf("seq%0d_off%0d", d, o), 10'(d ? six_b : six_a), 10'(tab[i].exp));
        end
        a.start_i = 1'b0;
    endtask
    initial begin
        tab.push_back('{0, 0, 6'b011110});  tab.push_back('{0, 3, 6'b011110});
        tab.push_back('{0, 4, 6'b111110});  tab.push_back('{0, 5, 6'b111110});
        tab.push_back('{0, 6, 6'b011110});  tab.push_back('{0, 9, 6'b011110});
        tab.push_back('{0, 10, 6'b001110}); tab.push_back('{0, 13, 6'b001110});
        tab.push_back('{0, 14, 6'b000110}); tab.push_back('{0, 17, 6'b000110});
        tab.push_back('{0, 18, 6'b000010}); tab.push_back('{0, 21, 6'b000010});
        tab.push_back('{0, 22, 6'b000001}); tab.push_back('{0, 24, 6'b000001});
        tab.push_back('{1, 0, 6'b011110});  tab.push_back('{1, 1, 6'b111110});
        tab.push_back('{1, 2, 6'b011110});  tab.push_back('{1, 3, 6'b001110});
        tab.push_back('{1, 4, 6'b000110});  tab.push_back('{1, 5, 6'b000010});
        tab.push_back('{1, 6, 6'b000001});  tab.push_back('{1, 7, 6'b000001});
        a.start_i = 1'b0;
        b.start_i = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_a", got_a, idle_v);
        check("reset_b", got_b, idle_v);
        rst    = 1'b0;
        chk_en = 1;
        repeat (50) @(negedge clk);
        check("idle50", got_a, idle_v);
        run_seq(0, -1, -1, 25);
        run_seq(0, 7, 15, 25);
        a.start_i = 1'b1;
        for (int o = 0; o < 24; o++) begin
            @(negedge clk);
            if (o == 22) check("held_done", got_a, 10'b111_01_000_0_0);
            if (o == 23) begin
                check("held_rearm", got_a, 10'b001_10_111_0_1);
                a.start_i = 1'b0;
            end
        end
        repeat (25) @(negedge clk);
        a.start_i = 1'b1;
        @(negedge clk);
        a.start_i = 1'b0;
        repeat (12) @(negedge clk);
        #2 rst = 1'b1;
        #1 check("async_rst", got_a, idle_v);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("after_rst_idle", got_a, idle_v);
        run_seq(0, -1, -1, 25);
        run_seq(1, -1, -1, 8);
        repeat (400) begin
            @(negedge clk);
            a.start_i = $urandom_range(0, 5) == 0;
            b.start_i = $urandom_range(0, 3) == 0;
            rst       = $urandom_range(0, 99) == 0;
        end
        @(negedge clk);
        rst       = 1'b0;
        a.start_i = 1'b0;
        b.start_i = 1'b0;
        @(negedge clk);
        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
